// File: rtl/adat_tx_smux.sv
`default_nettype none
// ============================================================================
// Module   : adat_tx_smux
// Purpose  : ADAT optical transmitter (256-bit NRZI frames) with normal and
//            S/MUX2 channel mapping, staging buffer and underrun fill.
// Revision : 1.0 - initial release
// ============================================================================

module adat_tx_smux #(
    parameter int SAMPLE_W      = 24,
    parameter int UNDERRUN_MODE = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bit_en,
    input  logic                  smux_req,
    input  logic                  timecode,
    input  logic                  midi,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*SAMPLE_W-1:0] in_data,
    output logic                  bitstream_out,
    output logic                  frame_start,
    output logic                  smux_active,
    output logic                  underrun
);

    localparam logic [7:0] c_LAST_BIT = 8'd255;

    logic [255:0]     r_shift;
    logic [7:0]       r_bit_cnt;
    logic             r_bitstream;
    logic             r_frame_start;
    logic             r_underrun;
    logic             r_smux_active;
    logic             r_stage_full;
    logic             r_stage_half;
    logic [7:0][23:0] r_stage;
    logic [7:0][23:0] r_last;

    logic [7:0][23:0] w_ch;
    logic [7:0][23:0] w_audio;
    logic [255:0]     w_frame;
    logic             w_load;
    logic             w_mode_change;
    logic             w_underrun;
    logic             w_accept;
    logic             w_accept_smux;
    logic             w_half_eff;

    // Samples are left-justified into the 24-bit slot, LSBs zero-filled
    generate
        for (genvar c = 0; c < 8; c++) begin : g_ch
            assign w_ch[c] = 24'(in_data[c*SAMPLE_W +: SAMPLE_W]) << (24 - SAMPLE_W);
        end
    endgenerate

    assign w_load        = bit_en && (r_bit_cnt == c_LAST_BIT);
    assign w_mode_change = smux_req != r_smux_active;
    assign w_underrun    = !r_stage_full || w_mode_change;
    assign w_audio       = !w_underrun ? r_stage :
                           (UNDERRUN_MODE != 0) ? r_last : '0;

    // A set accepted on a load cycle is staged under the mode that load selects
    assign w_accept      = in_valid && !r_stage_full;
    assign w_accept_smux = w_load ? smux_req : r_smux_active;
    assign w_half_eff    = r_stage_half && !(w_load && w_mode_change);

    always_comb begin
        w_frame          = '0;
        w_frame[255:240] = {1'b1, 10'b0, 1'b1, timecode, midi, smux_req, 1'b0};
        for (int s = 0; s < 8; s++) begin
            for (int g = 0; g < 6; g++) begin
                w_frame[239 - 30*s - 5*g]      = 1'b1;
                w_frame[238 - 30*s - 5*g -: 4] = w_audio[s][23 - 4*g -: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift       <= '0;
            r_bit_cnt     <= c_LAST_BIT;
            r_bitstream   <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_smux_active <= 1'b0;
            r_last        <= '0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && w_underrun;
            if (bit_en) begin
                r_bitstream <= r_bitstream ^ r_shift[255];
                r_bit_cnt   <= r_bit_cnt + 8'd1;
                r_shift     <= w_load ? w_frame : {r_shift[254:0], 1'b0};
            end
            if (w_load) begin
                r_smux_active <= smux_req;
                if (!w_underrun) begin
                    r_last <= r_stage;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage      <= '0;
            r_stage_full <= 1'b0;
            r_stage_half <= 1'b0;
        end else begin
            // A partial S/MUX set A survives an underrun but not a mode change
            if (w_load && (w_mode_change || r_stage_full)) begin
                r_stage_full <= 1'b0;
                r_stage_half <= 1'b0;
            end
            if (w_accept) begin
                if (!w_accept_smux) begin
                    r_stage      <= w_ch;
                    r_stage_full <= 1'b1;
                    r_stage_half <= 1'b0;
                end else if (!w_half_eff) begin
                    for (int c = 0; c < 4; c++) begin
                        r_stage[2*c] <= w_ch[c];
                    end
                    r_stage_half <= 1'b1;
                end else begin
                    for (int c = 0; c < 4; c++) begin
                        r_stage[2*c+1] <= w_ch[c];
                    end
                    r_stage_full <= 1'b1;
                    r_stage_half <= 1'b0;
                end
            end
        end
    end

    assign in_ready      = !r_stage_full;
    assign bitstream_out = r_bitstream;
    assign frame_start   = r_frame_start;
    assign smux_active   = r_smux_active;
    assign underrun      = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_adat_tx_smux.sv
`default_nettype none
// ============================================================================
// Module   : tb_adat_tx_smux
// Purpose  : Scoreboard bench for adat_tx_smux; zero-fill and repeat-fill
//            instances run side by side on shared stimulus.
// Revision : 1.0 - initial release
// ============================================================================

module tb_adat_tx_smux;

    localparam int SW = 24;

    typedef struct {
        logic [255:0] frame;
        logic         ur;
        logic         sm;
    } exp_t;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          bit_en    = 1'b0;
    logic          smux_req  = 1'b0;
    logic          timecode  = 1'b0;
    logic          midi      = 1'b0;
    logic          in_valid  = 1'b0;
    logic [8*SW-1:0] in_data = '0;
    logic [1:0]    in_ready;
    logic [1:0]    bs;
    logic [1:0]    fs;
    logic [1:0]    sa;
    logic [1:0]    ur;

    int            n_vec     = 0;
    int            n_err     = 0;
    int            div       = 1;
    bit            chk_hold  = 1'b0;
    logic [191:0]  last_good = '0;
    exp_t          q0[$];
    exp_t          q1[$];

    always #5 clk = ~clk;

    adat_tx_smux #(.SAMPLE_W(SW), .UNDERRUN_MODE(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .smux_req(smux_req),
        .timecode(timecode), .midi(midi), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .bitstream_out(bs[0]), .frame_start(fs[0]),
        .smux_active(sa[0]), .underrun(ur[0])
    );

    adat_tx_smux #(.SAMPLE_W(SW), .UNDERRUN_MODE(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bit_en(bit_en), .smux_req(smux_req),
        .timecode(timecode), .midi(midi), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .bitstream_out(bs[1]), .frame_start(fs[1]),
        .smux_active(sa[1]), .underrun(ur[1])
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, then slot 0..7 as six {1,nibble} groups MSB first
    function automatic logic [255:0] mk(bit tc, bit md, bit sm, logic [191:0] sl);
        logic [255:0] f;
        int p;
        f          = '0;
        f[255:240] = {1'b1, 10'b0, 1'b1, tc, md, sm, 1'b0};
        for (int s = 0; s < 8; s++) begin
            for (int g = 0; g < 6; g++) begin
                p          = 239 - 30*s - 5*g;
                f[p]       = 1'b1;
                f[p-1 -: 4] = sl[s*24 + 20 - 4*g +: 4];
            end
        end
        return f;
    endfunction

    task automatic push_exp(input bit tc, input bit md, input bit sm, input bit u,
                            input logic [191:0] good);
        exp_t e0, e1;
        e0.ur = u; e0.sm = sm;
        e1.ur = u; e1.sm = sm;
        if (!u) begin
            e0.frame  = mk(tc, md, sm, good);
            e1.frame  = e0.frame;
            last_good = good;
        end else begin
            e0.frame = mk(tc, md, sm, '0);
            e1.frame = mk(tc, md, sm, last_good);
        end
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic wait_load(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!fs[0] && cyc < 3000);
        if (!fs[0]) chk("load_timeout", fs, 2'b11);
        @(negedge clk);
    endtask

    task automatic send_set(input logic [8*SW-1:0] d);
        int t;
        t        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready[0] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[0]) chk("ready_timeout", in_ready, 2'b11);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph++;
            bit_en = (div == 1) || (ph % 4 == 0);
        end
    end

    // NRZI decoder / frame collector for both instances
    logic [255:0] cap [2];
    logic [255:0] want[2];
    int           cnt [2];
    bit           coll[2];
    logic         prev[2];
    logic         last_bs[2];

    initial begin
        exp_t e;
        bit   got;
        logic b;
        for (int i = 0; i < 2; i++) begin
            coll[i] = 0; prev[i] = 1'b0; last_bs[i] = 1'b0; cnt[i] = 0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!reset_n) begin
                    coll[i] = 0;
                    prev[i] = 1'b0;
                end else begin
                    if (chk_hold && !bit_en) chk($sformatf("hold[%0d]", i), bs[i], last_bs[i]);
                    if (bit_en) begin
                        b       = bs[i] ^ prev[i];
                        prev[i] = bs[i];
                        if (coll[i]) begin
                            cap[i] = {cap[i][254:0], b};
                            cnt[i]++;
                            if (cnt[i] == 256) begin
                                chk($sformatf("frame[%0d]", i), cap[i], want[i]);
                                coll[i] = 0;
                            end
                        end
                        if (fs[i]) begin
                            got = 0;
                            if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1; end
                            if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1; end
                            if (got) begin
                                chk($sformatf("underrun[%0d]", i), ur[i], e.ur);
                                chk($sformatf("smux_active[%0d]", i), sa[i], e.sm);
                                want[i] = e.frame;
                                coll[i] = 1;
                                cnt[i]  = 0;
                            end
                        end
                    end
                end
                last_bs[i] = bs[i];
            end
        end
    end

    initial begin
        int cyc, t;
        logic [191:0] dn, da, db, ds, dd;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bitstream", bs, 2'b00);
        chk("rst_frame_start", fs, 2'b00);
        chk("rst_underrun", ur, 2'b00);
        chk("rst_smux_active", sa, 2'b00);
        chk("rst_in_ready", in_ready, 2'b11);

        push_exp(0, 0, 0, 1, '0);
        reset_n = 1'b1;
        wait_load(cyc);
        timecode = 1'b1;
        push_exp(1, 0, 0, 1, '0);

        wait_load(cyc);
        midi = 1'b1;
        dn = '0;
        dn[0 +: 24]    = 24'h123456;
        dn[7*24 +: 24] = 24'hFEDCBA;
        send_set(dn);
        chk("ready_after_set", in_ready, 2'b00);
        push_exp(1, 1, 0, 0, dn);

        wait_load(cyc);
        chk("ready_after_load", in_ready, 2'b11);
        push_exp(1, 1, 0, 1, '0);

        wait_load(cyc);
        smux_req = 1'b1;
        push_exp(1, 1, 1, 1, '0);

        wait_load(cyc);
        chk("smux_on", sa, 2'b11);
        da = {24'hDEAD07, 24'hDEAD06, 24'hDEAD05, 24'hDEAD04,
              24'h333333, 24'h222222, 24'hAAAAAA, 24'h111111};
        send_set(da);
        chk("ready_half_set", in_ready, 2'b11);
        push_exp(1, 1, 1, 1, '0);

        wait_load(cyc);
        db = {24'hBEEF07, 24'hBEEF06, 24'hBEEF05, 24'hBEEF04,
              24'h777777, 24'h666666, 24'h555555, 24'h444444};
        send_set(db);
        chk("ready_pair_set", in_ready, 2'b00);
        for (int c = 0; c < 4; c++) begin
            ds[(2*c)*24   +: 24] = da[c*24 +: 24];
            ds[(2*c+1)*24 +: 24] = db[c*24 +: 24];
        end
        push_exp(1, 1, 1, 0, ds);

        wait_load(cyc);
        smux_req = 1'b0;
        push_exp(1, 1, 0, 1, '0);

        wait_load(cyc);
        div      = 4;
        chk_hold = 1'b1;
        dd = {24'h0F0F0F, 24'hC3C3C3, 24'h000001, 24'h800000,
              24'h9ABCDE, 24'h13579B, 24'hFFFFFF, 24'h2468AC};
        send_set(dd);
        push_exp(1, 1, 0, 0, dd);

        wait_load(cyc);
        push_exp(1, 1, 0, 1, '0);
        wait_load(cyc);
        chk("frame_period", cyc, 1024);

        t = 0;
        while (t < 100) begin
            @(posedge clk);
            if (bit_en) t++;
        end
        t = 0;
        while (bs != 2'b11 && t < 1024) begin
            @(posedge clk); #1;
            t++;
        end
        @(negedge clk);
        chk_hold = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("midrst_bitstream", bs, 2'b00);
        chk("midrst_in_ready", in_ready, 2'b11);
        chk("midrst_frame_start", fs, 2'b00);

        div       = 1;
        last_good = '0;
        repeat (2) @(negedge clk);
        push_exp(1, 1, 0, 1, '0);
        reset_n = 1'b1;
        wait_load(cyc);
        wait_load(cyc);
        chk("queue_drain", q0.size() + q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
